// File: rtl/sum_accumulator.sv
// rtl/sum_accumulator.sv - batch accumulator for {carryout,sum} beats from the 4-bit ripple adder
//
// Accumulates NSAMP five-bit beats (0..31) into an ACC_W-bit running total and
// holds the batch result, beat count and overflow flag until the sink accepts it.
//
// Optional feature macro: ACC_SATURATE_EN
//   defined   -> acc_out clamps to 2^ACC_W-1 on an overflowing accept
//   undefined -> acc_out wraps modulo 2^ACC_W
//   overflow is set identically in both builds.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   start      in   1      begins a batch (honoured only in IDLE)
//   in_valid   in   1      beat valid
//   in_ready   out  1      beat accepted this cycle when in_valid is high
//   sum        in   4      adder sum
//   carryout   in   1      adder carry out (MSB of the beat value)
//   out_valid  out  1      batch result valid
//   out_ready  in   1      sink accepts the result
//   acc_out    out  ACC_W  running / final total
//   count_out  out  CNT_W  beats accepted in the current batch
//   overflow   out  1      sticky: total exceeded 2^ACC_W-1 in this batch
//   busy       out  1      state is not IDLE

module sum_accumulator #(
    parameter int ACC_W = 12,
    parameter int NSAMP = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       sum,
    input  logic             carryout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] count_out,
    output logic             overflow,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic             accept;
    logic             last_beat;
    logic [ACC_W:0]   add_ext;
    logic [ACC_W:0]   sum_ext;
    logic [ACC_W-1:0] acc_nxt;

    // Outputs decode from state only, so there is no input-to-output path.
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);

    assign accept    = (state == ACCUM) && in_valid;
    assign last_beat = accept && (count_out == CNT_W'(NSAMP - 1));

    // One extra bit above the accumulator catches the carry out of the add.
    assign add_ext = {{(ACC_W - 4){1'b0}}, carryout, sum};
    assign sum_ext = {1'b0, acc_out} + add_ext;

`ifdef ACC_SATURATE_EN
    // Once clamped, any further add carries out again (or adds zero), so the
    // value stays pinned at full scale for the rest of the batch.
    assign acc_nxt = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    assign acc_nxt = sum_ext[ACC_W-1:0];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)     state_nxt = ACCUM;
            ACCUM:   if (last_beat) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_out   <= '0;
            count_out <= '0;
            overflow  <= 1'b0;
        end else if ((state == IDLE) && start) begin
            acc_out   <= '0;
            count_out <= '0;
            overflow  <= 1'b0;
        end else if (accept) begin
            acc_out   <= acc_nxt;
            count_out <= count_out + 1'b1;
            overflow  <= overflow | sum_ext[ACC_W];
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb/tb_sum_accumulator.sv - self-checking bench for sum_accumulator

module tb_sum_accumulator;

    localparam int AW_A = 12;
    localparam int NS_A = 8;
    localparam int AW_B = 6;
    localparam int NS_B = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [1:0] st, iv, ordy;
    logic [4:0] val_a, val_b;
    logic [1:0] ir, ovld, ovf, bsy;
    logic [11:0] acc_a;
    logic [5:0]  acc_b;
    logic [3:0]  cnt_a, cnt_b;

    int n_pass  = 0;
    int n_total = 0;

    sum_accumulator #(.ACC_W(AW_A), .NSAMP(NS_A), .CNT_W(4)) dut_a (
        .clk(clk), .reset(reset), .start(st[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .sum(val_a[3:0]), .carryout(val_a[4]), .out_valid(ovld[0]), .out_ready(ordy[0]),
        .acc_out(acc_a), .count_out(cnt_a), .overflow(ovf[0]), .busy(bsy[0])
    );

    sum_accumulator #(.ACC_W(AW_B), .NSAMP(NS_B), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .start(st[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .sum(val_b[3:0]), .carryout(val_b[4]), .out_valid(ovld[1]), .out_ready(ordy[1]),
        .acc_out(acc_b), .count_out(cnt_b), .overflow(ovf[1]), .busy(bsy[1])
    );

    typedef struct {
        bit sel;
        int val;
        int maxgap;
        int exp_acc;
        int exp_ovf;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int acc_of(input bit s);
        return s ? int'(acc_b) : int'(acc_a);
    endfunction

    function automatic int cnt_of(input bit s);
        return s ? int'(cnt_b) : int'(cnt_a);
    endfunction

    task automatic drive(input bit s, input bit a_st, input bit a_iv, input logic [4:0] v, input bit a_or);
        st[s]   = a_st;
        iv[s]   = a_iv;
        ordy[s] = a_or;
        if (s) val_b = v;
        else   val_a = v;
    endtask

    // Reference: the unbounded integer total, mapped into the register's range.
    function automatic int model_acc(input int total, input int w);
        int mx;
        mx = (1 << w) - 1;
        if (total <= mx) return total;
`ifdef ACC_SATURATE_EN
        return mx;
`else
        return total % (mx + 1);
`endif
    endfunction

    task automatic run_batch(input bit s, input int beats[$], input int maxgap,
                             output int final_acc, output int final_ovf);
        int ns, w, mx, total, edges, gap, held;
        logic [4:0] v;
        ns = s ? NS_B : NS_A;
        w  = s ? AW_B : AW_A;
        mx = (1 << w) - 1;
        total = 0;
        edges = 0;

        drive(s, 1'b1, 1'b0, 5'd0, 1'b0);
        tick;
        chk("start_acc_clear", acc_of(s), 0);
        chk("start_cnt_clear", cnt_of(s), 0);
        chk("start_ovf_clear", int'(ovf[s]), 0);
        chk("accum_in_ready", int'(ir[s]), 1);
        chk("accum_busy", int'(bsy[s]), 1);

        foreach (beats[i]) begin
            gap = $urandom_range(0, maxgap);
            repeat (gap) begin
                drive(s, 1'($urandom_range(0, 1)), 1'b0, 5'($urandom), 1'b0);
                tick;
                edges++;
                chk("stall_count", cnt_of(s), i);
                chk("stall_acc", acc_of(s), model_acc(total, w));
            end
            v = 5'(beats[i]);
            drive(s, 1'($urandom_range(0, 1)), 1'b1, v, 1'b0);
            tick;
            edges++;
            total += int'(v);
            chk("beat_count", cnt_of(s), i + 1);
            chk("beat_acc", acc_of(s), model_acc(total, w));
            chk("beat_ovf", int'(ovf[s]), int'(total > mx));
            chk("out_valid_timing", int'(ovld[s]), int'(i == ns - 1));
        end
        if (maxgap == 0) chk("batch_latency", edges, ns);

        held = acc_of(s);
        for (int k = 0; k < 5; k++) begin
            drive(s, k == 2, 1'($urandom_range(0, 1)), 5'($urandom), 1'b0);
            tick;
            chk("hold_out_valid", int'(ovld[s]), 1);
            chk("hold_acc", acc_of(s), held);
            chk("hold_count", cnt_of(s), ns);
            chk("hold_in_ready", int'(ir[s]), 0);
        end

        // start alongside out_ready must not launch a new batch
        drive(s, 1'b1, 1'b0, 5'd0, 1'b1);
        tick;
        chk("release_out_valid", int'(ovld[s]), 0);
        chk("release_busy", int'(bsy[s]), 0);
        chk("release_in_ready", int'(ir[s]), 0);
        chk("release_acc_held", acc_of(s), held);

        drive(s, 1'b0, 1'b1, 5'd7, 1'b0);
        repeat (2) tick;
        chk("idle_ignores_valid_cnt", cnt_of(s), ns);
        chk("idle_ignores_valid_acc", acc_of(s), held);
        chk("idle_busy", int'(bsy[s]), 0);
        drive(s, 1'b0, 1'b0, 5'd0, 1'b0);

        final_acc = held;
        final_ovf = int'(total > mx);
    endtask

    vec_t vecs[4];
    int   q[$];
    int   fa, fo, nb;
    bit   s;

    initial begin
        vecs[0] = '{sel: 1'b0, val: 31, maxgap: 0, exp_acc: 248, exp_ovf: 0};
        vecs[1] = '{sel: 1'b0, val: 5,  maxgap: 3, exp_acc: 40,  exp_ovf: 0};
        vecs[2] = '{sel: 1'b0, val: 2,  maxgap: 0, exp_acc: 16,  exp_ovf: 0};
`ifdef ACC_SATURATE_EN
        vecs[3] = '{sel: 1'b1, val: 31, maxgap: 0, exp_acc: 63,  exp_ovf: 1};
`else
        vecs[3] = '{sel: 1'b1, val: 31, maxgap: 0, exp_acc: 29,  exp_ovf: 1};
`endif

        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 1'b0);
        repeat (2) tick;
        reset = 1'b0;
        chk("reset_acc_a", acc_of(1'b0), 0);
        chk("reset_cnt_a", cnt_of(1'b0), 0);
        chk("reset_flags_a", int'({ir[0], ovld[0], ovf[0], bsy[0]}), 0);
        chk("reset_flags_b", int'({ir[1], ovld[1], ovf[1], bsy[1]}), 0);

        // reset mid-batch discards the partial total
        drive(1'b0, 1'b1, 1'b0, 5'd0, 1'b0);
        tick;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
            tick;
        end
        chk("pre_reset_cnt", cnt_of(1'b0), 3);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 5'd9, 1'b0);
        tick;
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
        chk("midreset_acc", acc_of(1'b0), 0);
        chk("midreset_cnt", cnt_of(1'b0), 0);
        chk("midreset_flags", int'({ir[0], ovld[0], ovf[0], bsy[0]}), 0);
        tick;
        chk("midreset_stays_idle", int'(bsy[0]), 0);

        foreach (vecs[r]) begin
            q  = {};
            nb = vecs[r].sel ? NS_B : NS_A;
            repeat (nb) q.push_back(vecs[r].val);
            run_batch(vecs[r].sel, q, vecs[r].maxgap, fa, fo);
            chk("vec_acc", fa, vecs[r].exp_acc);
            chk("vec_ovf", fo, vecs[r].exp_ovf);
        end

        for (int b = 0; b < 16; b++) begin
            s  = 1'($urandom_range(0, 1));
            nb = s ? NS_B : NS_A;
            q  = {};
            repeat (nb) q.push_back($urandom_range(0, 31));
            run_batch(s, q, 2, fa, fo);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
